// File: rtl/lcd_reader.sv
// HD44780-style 4-bit read sequencer: busy-flag/address or data byte reads,
// with optional busy polling until bit 7 clears or a read limit is reached.
module lcd_reader #(
    parameter int T_AS      = 2,
    parameter int T_EH      = 12,
    parameter int T_EL      = 40,
    parameter int MAX_POLLS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    input  logic [3:0] lcd_d,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       timeout,
    output logic       sf_e,
    output logic       e,
    output logic       rs,
    output logic       rw
);
    typedef enum logic [2:0] {IDLE, SETUP, EHI, ELO, DONE} state_t;

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic        hi, hi_n;
    logic [7:0]  shadow, shadow_n;
    logic        rs_q, rs_n;
    logic        poll_q, poll_n;
    logic [7:0]  cnt, cnt_n, cnt_inc;
    logic [7:0]  rd_data_q, rd_data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            hi        <= 1'b0;
            shadow    <= '0;
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            cnt       <= '0;
            rd_data_q <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            hi        <= hi_n;
            shadow    <= shadow_n;
            rs_q      <= rs_n;
            poll_q    <= poll_n;
            cnt       <= cnt_n;
            rd_data_q <= rd_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer + 16'd1;
        hi_n      = hi;
        shadow_n  = shadow;
        rs_n      = rs_q;
        poll_n    = poll_q;
        cnt_n     = cnt;
        rd_data_n = rd_data_q;
        cnt_inc   = cnt + 8'd1;
        ready     = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = rd_data_q;
        timeout   = 1'b0;
        sf_e      = 1'b1;
        e         = 1'b0;
        rs        = rs_q;
        rw        = 1'b1;

        case (state)
            IDLE: begin
                ready   = 1'b1;
                rs      = 1'b0;
                rw      = 1'b0;
                timer_n = '0;
            end
            SETUP: begin
                if (timer == 16'(T_AS - 1)) begin
                    timer_n = '0;
                    hi_n    = 1'b1;
                    state_n = EHI;
                end
            end
            EHI: begin
                e = 1'b1;
                if (timer == 16'(T_EH - 1)) begin
                    if (hi) shadow_n[7:4] = lcd_d;
                    else    shadow_n[3:0] = lcd_d;
                    timer_n = '0;
                    state_n = ELO;
                end
            end
            ELO: begin
                if (timer == 16'(T_EL - 1)) begin
                    timer_n = '0;
                    if (hi) begin
                        hi_n    = 1'b0;
                        state_n = EHI;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                timer_n = '0;
                cnt_n   = cnt_inc;
                // Keep polling with RS/RW held; the bus is never released between reads.
                if (poll_q && shadow[7] && (cnt_inc < 8'(MAX_POLLS))) begin
                    hi_n    = 1'b1;
                    state_n = EHI;
                end else begin
                    ready     = 1'b1;
                    rd_valid  = 1'b1;
                    rd_data   = shadow;
                    rd_data_n = shadow;
                    timeout   = poll_q & shadow[7];
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (ready && req) begin
            rs_n    = rs_sel;
            poll_n  = poll & ~rs_sel;
            cnt_n   = '0;
            timer_n = '0;
            state_n = SETUP;
        end
    end
endmodule
